// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sync_fifo write port among
// N valid/ready producers. An owner keeps the port for at most BURST words,
// and no write is issued while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_write,
  output logic [WIDTH-1:0]     fifo_data_in,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           st, st_n;
  logic [IDW-1:0]   owner, owner_n;
  logic [IDW-1:0]   last, last_n;
  logic [IDW-1:0]   pick;
  logic [CW-1:0]    cnt, cnt_n;
  logic             owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic             xfer;

  // Round-robin search starting just after the last granted index.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] v,
                                             input logic [IDW-1:0] l);
    logic [IDW-1:0] p;
    logic           found;
    int             idx;
    p     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(l) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == idx) && v[i]) begin
          p     = IDW'(i);
          found = 1'b1;
        end
      end
    end
    return p;
  endfunction

  // Select the current owner's valid bit and data word.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IDW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register; only control state is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      owner <= '0;
      last  <= IDW'(N - 1);
      cnt   <= '0;
    end else begin
      st    <= st_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and transfer outputs; reset gates the write in the same cycle.
  always_comb begin
    st_n         = st;
    owner_n      = owner;
    last_n       = last;
    cnt_n        = cnt;
    xfer         = 1'b0;
    fifo_write   = 1'b0;
    req_ready    = '0;
    fifo_data_in = '0;
    pick         = rr_pick(req_valid, last);

    case (st)
      IDLE: begin
        if (|req_valid) begin
          st_n    = OWN;
          owner_n = pick;
          last_n  = pick;
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (!owner_valid) begin
          // Owner withdrew: release without a transfer, full or not.
          st_n  = IDLE;
          cnt_n = '0;
        end else if (!fifo_full) begin
          xfer = 1'b1;
          if (cnt == CW'(BURST - 1)) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        // Owner valid and FIFO full: stall with everything held.
      end
      default: st_n = IDLE;
    endcase

    if (xfer && !rst) begin
      fifo_write   = 1'b1;
      fifo_data_in = owner_data;
      for (int i = 0; i < N; i++) begin
        if (owner == IDW'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  assign grant_valid = (st == OWN);
  assign grant_id    = grant_valid ? owner : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle tables for N=4/BURST=4 with a write
// scoreboard, plus a hand sequence on an N=3/BURST=1 instance.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data_in;
  logic        grant_valid;
  logic [1:0]  grant_id;

  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  r3;
  logic        w3;
  logic [7:0]  di3;
  logic        gv3;
  logic [1:0]  gid3;

  int checks   = 0;
  int failures = 0;
  int cur_row;

  logic [7:0] base [4];
  int         seqc [4];

  typedef struct {
    logic       r;
    logic [3:0] v;
    logic       f;
    logic       wr;
    logic       gv;
    logic [1:0] gid;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] d;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .BURST(4)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  fifo_wr_arbiter #(.N(3), .WIDTH(8), .BURST(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3),
    .req_ready(r3), .fifo_full(fifo_full), .fifo_write(w3),
    .fifo_data_in(di3), .grant_valid(gv3), .grant_id(gid3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", nm, cur_row, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic f,
                              input logic wr, input logic gv, input logic [1:0] gid,
                              input logic [7:0] d);
    vec_t e;
    e.r = r; e.v = v; e.f = f; e.wr = wr; e.gv = gv; e.gid = gid; e.d = d;
    tbl.push_back(e);
  endfunction

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + 8'(seqc[i]);
  endtask

  task automatic run_table(input string nm);
    logic [3:0] rdy_s;
    logic [3:0] exp_rdy;
    sb_t        s;
    for (int i = 0; i < 4; i++) seqc[i] = 0;
    for (int k = 0; k < tbl.size(); k++) begin
      cur_row   = k;
      rst       = tbl[k].r;
      req_valid = tbl[k].v;
      fifo_full = tbl[k].f;
      drive_data();
      if (tbl[k].wr) begin
        s.id = tbl[k].gid;
        s.d  = tbl[k].d;
        sbq.push_back(s);
      end
      exp_rdy = tbl[k].wr ? (4'b0001 << tbl[k].gid) : 4'b0000;
      @(negedge clk);
      chk({nm, ".write"}, 32'(fifo_write), 32'(tbl[k].wr));
      chk({nm, ".ready"}, 32'(req_ready), 32'(exp_rdy));
      chk({nm, ".gvalid"}, 32'(grant_valid), 32'(tbl[k].gv));
      chk({nm, ".gid"}, 32'(grant_id), 32'(tbl[k].gid));
      chk({nm, ".data"}, 32'(fifo_data_in), tbl[k].wr ? 32'(tbl[k].d) : 32'd0);
      if (fifo_write) begin
        if (sbq.size() == 0) begin
          chk({nm, ".sb_unexpected_write"}, 32'd1, 32'd0);
        end else begin
          s = sbq.pop_front();
          chk({nm, ".sb_id"}, 32'(grant_id), 32'(s.id));
          chk({nm, ".sb_data"}, 32'(fifo_data_in), 32'(s.d));
        end
      end
      rdy_s = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (rdy_s[i]) seqc[i]++;
    end
    cur_row = tbl.size();
    chk({nm, ".sb_left"}, 32'(sbq.size()), 32'd0);
    sbq.delete();
    tbl.delete();
  endtask

  initial begin
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    for (int i = 0; i < 4; i++) seqc[i] = 0;
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; v3 = '0;
    d3 = {8'h53, 8'h52, 8'h51};
    drive_data();
    @(posedge clk);
    #1;

    // Single burst, then owner drop.
    add(1, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h1, 0, 0, 0, 0, 8'h00);
    add(0, 4'h1, 0, 1, 1, 0, 8'hA0);
    add(0, 4'h1, 0, 1, 1, 0, 8'hA1);
    add(0, 4'h1, 0, 1, 1, 0, 8'hA2);
    add(0, 4'h1, 0, 1, 1, 0, 8'hA3);
    add(0, 4'h1, 0, 0, 0, 0, 8'h00);
    add(0, 4'h1, 0, 1, 1, 0, 8'hA4);
    add(0, 4'h0, 0, 0, 1, 0, 8'h00);
    add(0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_table("single");

    // Round-robin fairness: 0,1,2,3,0 with one idle cycle between bursts.
    add(1, 4'h0, 0, 0, 0, 0, 8'h00);
    for (int b = 0; b < 5; b++) begin
      add(0, 4'hF, 0, 0, 0, 0, 8'h00);
      for (int w = 0; w < 4; w++)
        add(0, 4'hF, 0, 1, 1, 2'(b % 4), base[b % 4] + 8'((b / 4) * 4 + w));
    end
    add(0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_table("fair");

    // Full stall with owner 1 at cnt=2.
    add(1, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h2, 0, 0, 0, 0, 8'h00);
    add(0, 4'h2, 0, 1, 1, 1, 8'hB0);
    add(0, 4'h2, 0, 1, 1, 1, 8'hB1);
    add(0, 4'h2, 1, 0, 1, 1, 8'h00);
    add(0, 4'h2, 1, 0, 1, 1, 8'h00);
    add(0, 4'h2, 1, 0, 1, 1, 8'h00);
    add(0, 4'h2, 0, 1, 1, 1, 8'hB2);
    add(0, 4'h2, 0, 1, 1, 1, 8'hB3);
    add(0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_table("stall");

    // Early release by owner 1, then 2, then 3 shows last advancing.
    add(1, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h6, 0, 0, 0, 0, 8'h00);
    add(0, 4'h6, 0, 1, 1, 1, 8'hB0);
    add(0, 4'h6, 0, 1, 1, 1, 8'hB1);
    add(0, 4'h4, 0, 0, 1, 1, 8'h00);
    add(0, 4'h4, 0, 0, 0, 0, 8'h00);
    add(0, 4'h4, 0, 1, 1, 2, 8'hC0);
    add(0, 4'h0, 0, 0, 1, 2, 8'h00);
    add(0, 4'hF, 0, 0, 0, 0, 8'h00);
    add(0, 4'hF, 0, 1, 1, 3, 8'hD0);
    add(0, 4'h0, 0, 0, 1, 3, 8'h00);
    add(0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_table("early");

    // Reset during owner 2's second transfer cycle.
    add(1, 4'h0, 0, 0, 0, 0, 8'h00);
    add(0, 4'h4, 0, 0, 0, 0, 8'h00);
    add(0, 4'h4, 0, 1, 1, 2, 8'hC0);
    add(1, 4'h4, 0, 0, 1, 2, 8'h00);
    add(0, 4'h5, 0, 0, 0, 0, 8'h00);
    add(0, 4'h5, 0, 1, 1, 0, 8'hA0);
    add(0, 4'h0, 0, 0, 1, 0, 8'h00);
    add(0, 4'h0, 0, 0, 0, 0, 8'h00);
    run_table("rstmid");

    // N=3, BURST=1: one word each, order 0,1,2,0, alternating with idle.
    begin
      logic [1:0] order [4];
      logic [1:0] g;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
      rst = 1'b1; req_valid = '0; v3 = '0;
      @(posedge clk);
      #1;
      rst = 1'b0; v3 = 3'b111;
      for (int c = 0; c < 8; c++) begin
        cur_row = c;
        @(negedge clk);
        if (c % 2 == 0) begin
          chk("b1.write", 32'(w3), 32'd0);
          chk("b1.gvalid", 32'(gv3), 32'd0);
          chk("b1.ready", 32'(r3), 32'd0);
          chk("b1.data", 32'(di3), 32'd0);
        end else begin
          g = order[c / 2];
          chk("b1.write", 32'(w3), 32'd1);
          chk("b1.gvalid", 32'(gv3), 32'd1);
          chk("b1.gid", 32'(gid3), 32'(g));
          chk("b1.ready", 32'(r3), 32'(3'b001 << g));
          chk("b1.data", 32'(di3), 32'(8'h51 + 8'(g)));
        end
        @(posedge clk);
        #1;
      end
      v3 = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
